// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields back into 32-bit instruction
// words and streams them into IMEM via a one-entry output register with an
// auto-incrementing byte address, flagging illegal fields and overflow.
module instr_encoder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [6:0]                   op_i,
    input  logic [4:0]                   rd_i,
    input  logic [2:0]                   funct3_i,
    input  logic [6:0]                   funct7_i,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    input  logic [31:0]                  imm_i,
    input  logic                         last_i,
    output logic                         wr_en_o,
    output logic [31:0]                  wr_addr_o,
    output logic [31:0]                  wr_data_o,
    input  logic                         wr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [1:0]                   err_code_o
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_IMM    = 2'b10;
    localparam logic [1:0] ERR_OVF    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            last_q, last_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;

    logic [31:0]     enc_word;
    logic            enc_legal;
    logic [1:0]      enc_code;
    logic            fits12, fits13, fits21, is_shift;
    logic            accept, complete;
    logic [CW-1:0]   count_inc;

    // Format the incoming field bundle by opcode and judge its legality.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        enc_code  = ERR_IMM;
        fits12    = (&imm_i[31:11]) || (~|imm_i[31:11]);
        fits13    = (&imm_i[31:12]) || (~|imm_i[31:12]);
        fits21    = (&imm_i[31:20]) || (~|imm_i[31:20]);
        is_shift  = (funct3_i == 3'b001) || (funct3_i == 3'b101);
        case (op_i)
            OP_R: begin
                enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
                enc_legal = 1'b1;
            end
            OP_LOAD, OP_JALR: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                enc_legal = fits12;
            end
            OP_IMM: begin
                if (is_shift) begin
                    enc_word  = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, op_i};
                    enc_legal = ~|imm_i[31:5];
                end else begin
                    enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                    enc_legal = fits12;
                end
            end
            OP_STORE: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                enc_legal = fits12;
            end
            OP_BRANCH: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], op_i};
                enc_legal = fits13 && !imm_i[0];
            end
            OP_LUI, OP_AUIPC: begin
                enc_word  = {imm_i[31:12], rd_i, op_i};
                enc_legal = ~|imm_i[11:0];
            end
            OP_JAL: begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                enc_legal = fits21 && !imm_i[0];
            end
            default: begin
                enc_legal = 1'b0;
                enc_code  = ERR_OPCODE;
            end
        endcase
    end

    // Next-state logic: start wins, then write completion (last/overflow), then accept.
    always_comb begin
        state_d    = state_q;
        wr_en_d    = wr_en_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        count_d    = count_q;
        done_d     = done_q;
        err_d      = err_q;
        code_d     = code_q;
        in_ready_o = (state_q == ST_RUN) && (!wr_en_q || wr_ready_i);
        accept     = in_valid_i && in_ready_o;
        complete   = wr_en_q && wr_ready_i;
        count_inc  = count_q + CW'(1);

        if (start_i) begin
            state_d = ST_RUN;
            wr_en_d = 1'b0;
            addr_d  = BASE_ADDR;
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (complete) begin
                        wr_en_d = 1'b0;
                        addr_d  = addr_q + 32'd4;
                        count_d = count_inc;
                    end
                    if (complete && last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (complete && (count_inc == CW'(DEPTH))) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        code_d  = ERR_OVF;
                    end else if (accept) begin
                        if (enc_legal) begin
                            wr_en_d = 1'b1;
                            data_d  = enc_word;
                            last_d  = last_i;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            code_d  = enc_code;
                        end
                    end
                end
                ST_ERR: begin
                    if (complete) begin
                        wr_en_d = 1'b0;
                        addr_d  = addr_q + 32'd4;
                        count_d = count_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign count_o    = count_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule
